inv_byte_permutation_unit: RTL and testbench
============================================

INV_BYTE_PERMUTATION_UNIT -- requirements
Module: inv_byte_permutation_unit

Interface
REQ-001 SHALL have parameter INVERSE, default 1, meaning: 1 = InvShiftRows mapping, 0 = forward ShiftRows mapping (cross-check mode).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_byte  input  8  state byte, column-major order (index k = row + 4*col).
REQ-005 SHALL have port in_valid  input  1  in_byte is valid.
REQ-006 SHALL have port in_ready  output  1  unit accepts in_byte this cycle.
REQ-007 SHALL have port out_byte  output  8  permuted byte, column-major order.
REQ-008 SHALL have port out_valid  output  1  out_byte is valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_byte.
REQ-010 SHALL have port out_last  output  1  out_byte is byte 15 of the block.

Function
REQ-011 SHALL transfer an input byte only in a cycle where in_valid=1 and in_ready=1, and an output byte only in a cycle where out_valid=1 and out_ready=1.
REQ-012 SHALL process 16-byte blocks; output byte k (row r = k mod 4, col c = k/4) SHALL equal input byte r + 4*((c - r) mod 4) when INVERSE=1, and r + 4*((c + r) mod 4) when INVERSE=0.
REQ-013 SHALL buffer data in two 16-byte banks (ping-pong); each bank SHALL be in one of the states EMPTY, FILLING, FULL, or DRAINING.
REQ-014 Bank transitions: EMPTY->FILLING on the first write; FILLING->FULL on the write of byte 15; FULL->DRAINING on the first read; DRAINING->EMPTY on the read of byte 15. FULL->EMPTY SHALL occur directly if the block is read in one step only when reading byte 15.
REQ-015 SHALL write into the write-bank selected by a 4-bit write pointer and toggle the write-bank select after byte 15; SHALL read from the read-bank selected by a 4-bit read pointer and toggle the read-bank select after byte 15. Both pointers SHALL wrap from 15 to 0.
REQ-016 in_ready SHALL be 1 if and only if the current write bank is EMPTY or FILLING.
REQ-017 out_valid SHALL be 1 if and only if the current read bank is FULL or DRAINING; out_valid SHALL first rise in the cycle after the byte-15 input handshake (latency 1 cycle from the last input to the first output).
REQ-018 SHALL sustain 1 byte/cycle throughput in both directions when in_valid=1 and out_ready=1 continuously; there SHALL be no bubbles between blocks.
REQ-019 When out_ready=0 while out_valid=1, out_byte, out_last, and the read pointer SHALL hold stable.
REQ-020 When both banks are FULL/DRAINING, in_ready SHALL be 0; a byte-15 read and a write in the same cycle SHALL both complete, with the freed bank becoming writable the next cycle.
REQ-021 out_byte SHALL be 8'h00 and out_last SHALL be 0 whenever out_valid=0.
REQ-022 in_valid=0 gaps mid-block SHALL pause filling without loss; the block SHALL resume at the same write pointer.

Reset
REQ-023 While rst=0, SHALL immediately (asynchronously) clear both banks to EMPTY, both pointers and both bank selects to 0, out_valid=0, out_byte=8'h00, out_last=0; in_ready SHALL be 1 after rst deasserts.
REQ-024 Reset mid-block SHALL discard any partial or pending blocks; the next accepted byte SHALL be byte 0 of a new block.
REQ-025 Bank data registers need not be reset.

Structure
REQ-026 Bank-state enum, BLOCK_BYTES=16, and the index-mapping function (inverse and forward) SHALL live in the shared AES package.
REQ-027 SHALL instantiate one sub-module, byte_bank_16: a 16x8 register bank with a write port and an indexed read port, used twice.
REQ-028 Control (bank FSMs, pointers) and datapath SHALL be separable, following the existing controller/datapath split.

Verification
REQ-029 INVERSE=1: input 00..0F back-to-back -> output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03, out_last on the 16th byte, first out_valid 1 cycle after the input 0F handshake.
REQ-030 INVERSE=0: input 00..0F -> output 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B; chaining the forward and inverse instances SHALL return 00..0F.
REQ-031 Four blocks streamed with in_valid=1 and out_ready=1 continuously -> 64 consecutive output bytes with no bubbles and correct per-block mapping.
REQ-032 out_ready=0 held for 20 cycles after the first output -> in_ready drops once 2 blocks are buffered; out_byte stays stable; no data is lost after out_ready=1 is restored.
REQ-033 rst asserted after 7 input bytes -> outputs clear immediately; a new block 10..1F SHALL produce the correctly mapped output with no trace of the old data.
REQ-034 Random in_valid/out_ready throttling over 1000 blocks -> matches the scoreboard model.

Source files
------------

// File: rtl/inv_byte_permutation_unit_pkg.sv
// Shared AES byte-permutation definitions: bank states, block size and the
// ShiftRows / InvShiftRows source-index mapping.
package inv_byte_permutation_unit_pkg;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [3:0] LAST_IDX    = 4'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  // Output byte k (row k[1:0], col k[3:2]) is taken from the same row,
  // column shifted by the row number; 2-bit arithmetic gives the mod-4 wrap.
  function automatic logic [3:0] src_index(input logic [3:0] k, input logic inverse);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = k[1:0];
    c  = k[3:2];
    sc = inverse ? (c - r) : (c + r);
    return {sc, r};
  endfunction

endpackage

// File: rtl/inv_byte_permutation_unit_bank.sv
// 16x8 register bank: one synchronous write port, one combinational indexed read port.
module byte_bank_16 (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [16];

  // Data is qualified by the bank state in the controller, so no reset here.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inv_byte_permutation_unit.sv
// Streaming (Inv)ShiftRows byte permuter: bytes in column-major order are
// buffered in two ping-pong banks and read back in permuted order.
module inv_byte_permutation_unit
  import inv_byte_permutation_unit_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  // ---------------- control ----------------
  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic        wr_sel;
  logic        rd_sel;
  logic        wr_fire;
  logic        rd_fire;

  assign in_ready  = (state_q[wr_sel] == BANK_EMPTY) || (state_q[wr_sel] == BANK_FILLING);
  assign out_valid = (state_q[rd_sel] == BANK_FULL)  || (state_q[rd_sel] == BANK_DRAINING);
  assign wr_fire   = in_valid  && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Write and read never target the same bank in one cycle: a bank that is
  // writable is by definition not readable.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (wr_fire && (wr_sel == 1'(b)))
        state_d[b] = (wr_ptr == LAST_IDX) ? BANK_FULL : BANK_FILLING;
      if (rd_fire && (rd_sel == 1'(b)))
        state_d[b] = (rd_ptr == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_ptr     <= 4'd0;
      rd_ptr     <= 4'd0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 4'd1;
        if (wr_ptr == LAST_IDX) wr_sel <= ~wr_sel;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 4'd1;
        if (rd_ptr == LAST_IDX) rd_sel <= ~rd_sel;
      end
    end
  end

  // ---------------- datapath ----------------
  logic [1:0][7:0] bank_rdata;
  logic [3:0]      rd_addr;

  assign rd_addr = src_index(rd_ptr, INVERSE);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    byte_bank_16 u_bank (
      .clk   (clk),
      .we    (wr_fire && (wr_sel == 1'(b))),
      .waddr (wr_ptr),
      .wdata (in_byte),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  assign out_byte = out_valid ? bank_rdata[rd_sel] : 8'h00;
  assign out_last = out_valid && (rd_ptr == LAST_IDX);

endmodule

// File: tb/tb_inv_byte_permutation_unit.sv
// Scoreboard bench for inv_byte_permutation_unit plus a forward->inverse chain.
module tb_inv_byte_permutation_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  // forward -> inverse chain
  logic [7:0] f_in_byte = 8'h00;
  logic       f_in_valid = 1'b0;
  logic       f_in_ready;
  logic [7:0] f_out_byte;
  logic       f_out_valid;
  logic       f_out_last;
  logic       c_in_ready;
  logic [7:0] c_out_byte;
  logic       c_out_valid;
  logic       c_out_last;
  logic       c_out_ready = 1'b1;

  inv_byte_permutation_unit #(.INVERSE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

  inv_byte_permutation_unit #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .in_byte(f_in_byte), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .out_byte(f_out_byte), .out_valid(f_out_valid), .out_ready(c_in_ready), .out_last(f_out_last));

  inv_byte_permutation_unit #(.INVERSE(1'b1)) u_chain (
    .clk(clk), .rst(rst), .in_byte(f_out_byte), .in_valid(f_out_valid), .in_ready(c_in_ready),
    .out_byte(c_out_byte), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_last(c_out_last));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  logic [8:0] sb [$];   // {last, byte}
  logic [7:0] fq [$];
  logic [8:0] cq [$];
  int  vmode = 0;       // 0: in_valid always 1, 2: random
  int  rmode = 0;       // 0: out_ready 1, 1: out_ready 0, 2: random
  bit  lat_chk = 1'b0;
  bit  bub_chk = 1'b0;
  int unsigned fire15_cyc = 0;
  int  npop = 0;

  logic [7:0] inv_tab [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] fwd_tab [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                               8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of InvShiftRows on a captured block.
  function automatic logic [7:0] model_inv(input logic [7:0] d [16], input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return d[r + 4 * ((c - r + 4) % 4)];
  endfunction

  task automatic send_block(input logic [7:0] d [16], input logic [7:0] e [16], input int n);
    for (int i = 0; i < n; i++) begin
      int tries;
      bit fired;
      tries = 0;
      fired = 1'b0;
      while (!fired) begin
        @(negedge clk);
        in_valid = (vmode == 2) ? ($urandom_range(3) != 0) : 1'b1;
        in_byte  = d[i];
        #1;
        fired = in_valid && in_ready;
        tries++;
        if (!fired && tries > 2000) begin
          $display("FAIL in_ready_timeout: byte %0d never accepted", i);
          $fatal(1, "stalled input");
        end
      end
      if (i == 15) begin
        for (int k = 0; k < 16; k++) sb.push_back({(k == 15), e[k]});
        fire15_cyc = cyc;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || cq.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drain_left", sb.size() + cq.size(), 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  // Monitor: drives out_ready and checks every DUT output against the queues.
  logic [7:0] held_byte;
  logic       held_last;
  bit         stall_prev = 1'b0;
  logic [8:0] e_m;
  initial begin
    forever begin
      @(negedge clk);
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(3) != 0);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          chk("hold_byte", out_byte, held_byte);
          chk("hold_last", out_last, held_last);
        end
        stall_prev = out_valid && !out_ready;
        held_byte  = out_byte;
        held_last  = out_last;
        if (lat_chk && out_valid) begin
          chk("latency", cyc, fire15_cyc + 1);
          lat_chk = 1'b0;
        end
        if (bub_chk && npop > 0 && npop < 64) chk("no_bubble", out_valid, 1);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_out: got %0h with empty scoreboard", out_byte);
          end else begin
            e_m = sb.pop_front();
            chk("out_byte", out_byte, e_m[7:0]);
            chk("out_last", out_last, e_m[8]);
          end
          npop++;
        end else if (!out_valid) begin
          chk("idle_zero", {out_last, out_byte}, 0);
        end
        if (f_out_valid && c_in_ready && fq.size() != 0)
          chk("fwd_byte", f_out_byte, fq.pop_front());
        if (c_out_valid && cq.size() != 0) begin
          e_m = cq.pop_front();
          chk("chain_byte", c_out_byte, e_m[7:0]);
          chk("chain_last", c_out_last, e_m[8]);
        end
      end
    end
  end

  logic [7:0] d [16];
  logic [7:0] e [16];

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // block 00..0F, back-to-back, latency and mapping
    lat_chk = 1'b1;
    for (int k = 0; k < 16; k++) begin d[k] = 8'(k); e[k] = inv_tab[k]; end
    send_block(d, e, 16);
    idle();
    wait_drain();
    chk("latency_seen", lat_chk, 0);

    // forward -> inverse chain returns the original order
    for (int k = 0; k < 16; k++) begin
      fq.push_back(fwd_tab[k]);
      cq.push_back({(k == 15), 8'(k)});
    end
    for (int i = 0; i < 16; i++) begin
      int tries;
      tries = 0;
      forever begin
        @(negedge clk);
        f_in_valid = 1'b1;
        f_in_byte  = 8'(i);
        #1;
        if (f_in_ready) break;
        tries++;
        if (tries > 2000) begin
          $display("FAIL chain_in_timeout: byte %0d", i);
          $fatal(1, "stalled chain");
        end
      end
    end
    @(negedge clk);
    f_in_valid = 1'b0;
    wait_drain();
    chk("fwd_queue_left", fq.size(), 0);

    // four blocks streamed with no bubbles
    npop = 0;
    bub_chk = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 16; k++) begin
        d[k] = 8'(16 * (b + 5) + k);
        e[k] = 8'(16 * (b + 5)) | inv_tab[k];
      end
      send_block(d, e, 16);
    end
    idle();
    wait_drain();
    bub_chk = 1'b0;
    chk("stream_count", npop, 64);

    // backpressure: two blocks fill both banks, in_ready must drop
    rmode = 1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 16; k++) begin
        d[k] = 8'(16 * (b + 2) + k);
        e[k] = 8'(16 * (b + 2)) | inv_tab[k];
      end
      if (b == 2) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'h99;
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_byte", out_byte, 8'h20);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rmode = 0;
      end
      send_block(d, e, 16);
    end
    idle();
    wait_drain();

    // reset with one pending block and a 7-byte partial block
    rmode = 1;
    for (int k = 0; k < 16; k++) begin d[k] = 8'(8'h60 + k); e[k] = 8'h60 | inv_tab[k]; end
    send_block(d, e, 16);
    send_block(d, e, 7);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_byte", out_byte, 0);
    chk("async_out_last", out_last, 0);
    sb.delete();
    @(negedge clk);
    #3 rst = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    rmode = 0;
    for (int k = 0; k < 16; k++) begin d[k] = 8'(8'h10 + k); e[k] = 8'h10 | inv_tab[k]; end
    send_block(d, e, 16);
    idle();
    wait_drain();

    // random throttling
    vmode = 2;
    rmode = 2;
    for (int b = 0; b < 1000; b++) begin
      for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
      for (int k = 0; k < 16; k++) e[k] = model_inv(d, k);
      send_block(d, e, 16);
    end
    idle();
    rmode = 0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
